// File: rtl/axi_txn_sequencer.sv
// axi_txn_sequencer: launches the splitter's per-port INIT_AXI_TXN handshakes in ascending order and gathers status.
// Optional feature macro AXI_TXN_SEQ_RETRY_EN: retry a failed channel once and expose retry_status.
module axi_txn_sequencer #(
  parameter int NUM_CH            = 3,
  parameter int INIT_PULSE_CYCLES = 2,
  parameter int GAP_CYCLES        = 20,
  parameter int TIMEOUT_CYCLES    = 4096,
  parameter int TMO_W             = 16
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              start,
  input  logic [NUM_CH-1:0] chan_mask,
  output logic [NUM_CH-1:0] init_txn,
  input  logic [NUM_CH-1:0] txn_done,
  input  logic [NUM_CH-1:0] txn_error,
  output logic              busy,
  output logic              seq_done,
  output logic [NUM_CH-1:0] err_status,
  output logic [NUM_CH-1:0] tmo_status,
  output logic [2:0]        cur_chan
`ifdef AXI_TXN_SEQ_RETRY_EN
  ,
  output logic [NUM_CH-1:0] retry_status
`endif
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SELECT = 3'd1;
  localparam logic [2:0] ST_GAP    = 3'd2;
  localparam logic [2:0] ST_PULSE  = 3'd3;
  localparam logic [2:0] ST_WAIT   = 3'd4;
  localparam logic [2:0] ST_NEXT   = 3'd5;
  localparam logic [2:0] ST_FINISH = 3'd6;

  localparam logic [2:0]       LAST_CH   = 3'(NUM_CH - 1);
  localparam logic [TMO_W-1:0] GAP_END   = TMO_W'(GAP_CYCLES - 1);
  localparam logic [TMO_W-1:0] PULSE_END = TMO_W'(INIT_PULSE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_END   = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] CNT_ONE   = TMO_W'(1'b1);
  localparam logic [TMO_W-1:0] CNT_ZERO  = {TMO_W{1'b0}};
  localparam logic [NUM_CH-1:0] CH_ZERO  = {NUM_CH{1'b0}};

  logic [2:0]        state_r;
  logic [2:0]        cur_chan_r;
  logic [TMO_W-1:0]  cnt_r;
  logic [NUM_CH-1:0] mask_r;
  logic [NUM_CH-1:0] init_txn_r;
  logic [NUM_CH-1:0] err_r;
  logic [NUM_CH-1:0] tmo_r;
  logic              busy_r;
  logic              seq_done_r;
  logic              done_prev_r;
`ifdef AXI_TXN_SEQ_RETRY_EN
  logic [NUM_CH-1:0] retry_r;
  logic              retry_used_r;
`endif

  logic [NUM_CH-1:0] cur_onehot_s;
  logic              sel_hit_s;
  logic              last_s;
  logic              done_cur_s;
  logic              err_cur_s;
  logic              rise_s;
  logic              tmo_hit_s;
  logic              fail_s;
  logic              retry_ok_s;

  // Per-channel views of the current channel and the WAIT exit conditions.
  always_comb begin
    cur_onehot_s = NUM_CH'(1'b1) << cur_chan_r;
    sel_hit_s    = |(mask_r & cur_onehot_s);
    last_s       = (cur_chan_r == LAST_CH);
    done_cur_s   = |(txn_done & cur_onehot_s);
    err_cur_s    = |(txn_error & cur_onehot_s);
    rise_s       = done_cur_s & ~done_prev_r;
    tmo_hit_s    = (cnt_r == TMO_END);
    // A completion in the timeout cycle is judged on its error flag, not as a timeout.
    fail_s       = rise_s ? err_cur_s : tmo_hit_s;
`ifdef AXI_TXN_SEQ_RETRY_EN
    retry_ok_s   = ~retry_used_r;
`else
    retry_ok_s   = 1'b0;
`endif
  end

  // Sequencer state machine and all registered outputs.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_r     <= ST_IDLE;
      cur_chan_r  <= 3'd0;
      cnt_r       <= CNT_ZERO;
      mask_r      <= CH_ZERO;
      init_txn_r  <= CH_ZERO;
      err_r       <= CH_ZERO;
      tmo_r       <= CH_ZERO;
      busy_r      <= 1'b0;
      seq_done_r  <= 1'b0;
      done_prev_r <= 1'b0;
`ifdef AXI_TXN_SEQ_RETRY_EN
      retry_r      <= CH_ZERO;
      retry_used_r <= 1'b0;
`endif
    end else begin
      seq_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start && !seq_done_r) begin
            mask_r     <= chan_mask;
            err_r      <= CH_ZERO;
            tmo_r      <= CH_ZERO;
            busy_r     <= 1'b1;
            cur_chan_r <= 3'd0;
            cnt_r      <= CNT_ZERO;
            state_r    <= ST_SELECT;
`ifdef AXI_TXN_SEQ_RETRY_EN
            retry_r    <= CH_ZERO;
`endif
          end
        end
        ST_SELECT: begin
          if (sel_hit_s) begin
            cnt_r <= CNT_ZERO;
`ifdef AXI_TXN_SEQ_RETRY_EN
            retry_used_r <= 1'b0;
`endif
            if (GAP_CYCLES == 32'sd0) begin
              init_txn_r <= cur_onehot_s;
              state_r    <= ST_PULSE;
            end else begin
              state_r <= ST_GAP;
            end
          end else if (last_s) begin
            state_r <= ST_FINISH;
          end else begin
            cur_chan_r <= cur_chan_r + 3'd1;
          end
        end
        ST_GAP: begin
          if (cnt_r == GAP_END) begin
            cnt_r      <= CNT_ZERO;
            init_txn_r <= cur_onehot_s;
            state_r    <= ST_PULSE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_PULSE: begin
          if (cnt_r == PULSE_END) begin
            cnt_r       <= CNT_ZERO;
            init_txn_r  <= CH_ZERO;
            done_prev_r <= done_cur_s;
            state_r     <= ST_WAIT;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_WAIT: begin
          done_prev_r <= done_cur_s;
          cnt_r       <= cnt_r + CNT_ONE;
          if (rise_s || tmo_hit_s) begin
            cnt_r <= CNT_ZERO;
            if (fail_s && retry_ok_s) begin
`ifdef AXI_TXN_SEQ_RETRY_EN
              retry_used_r <= 1'b1;
              retry_r      <= retry_r | cur_onehot_s;
`endif
              if (GAP_CYCLES == 32'sd0) begin
                init_txn_r <= cur_onehot_s;
                state_r    <= ST_PULSE;
              end else begin
                state_r <= ST_GAP;
              end
            end else begin
              if (rise_s) begin
                err_r <= err_r | (cur_onehot_s & {NUM_CH{err_cur_s}});
              end else begin
                tmo_r <= tmo_r | cur_onehot_s;
              end
              state_r <= ST_NEXT;
            end
          end
        end
        ST_NEXT: begin
          if (last_s) begin
            state_r <= ST_FINISH;
          end else begin
            cur_chan_r <= cur_chan_r + 3'd1;
            state_r    <= ST_SELECT;
          end
        end
        ST_FINISH: begin
          busy_r     <= 1'b0;
          seq_done_r <= 1'b1;
          state_r    <= ST_IDLE;
        end
        default: begin
          busy_r     <= 1'b0;
          init_txn_r <= CH_ZERO;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  assign init_txn   = init_txn_r;
  assign busy       = busy_r;
  assign seq_done   = seq_done_r;
  assign err_status = err_r;
  assign tmo_status = tmo_r;
  assign cur_chan   = cur_chan_r;
`ifdef AXI_TXN_SEQ_RETRY_EN
  assign retry_status = retry_r;
`endif

endmodule

// File: tb/tb_axi_txn_sequencer.sv
// Self-checking bench for axi_txn_sequencer: per-channel slave models driven from init_txn,
// with a timeline reference model derived from the sequencing rules.
module tb_axi_txn_sequencer;

  localparam int N    = 3;
  localparam int P    = 2;
  localparam int G    = 20;
  localparam int T    = 100;
  localparam int TW   = 16;
  localparam int MAXL = 1024;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] chan_mask = '0;
  logic [N-1:0] txn_done = '0;
  logic [N-1:0] txn_error = '0;
  logic [N-1:0] init_txn;
  logic         busy;
  logic         seq_done;
  logic [N-1:0] err_status;
  logic [N-1:0] tmo_status;
  logic [2:0]   cur_chan;
`ifdef AXI_TXN_SEQ_RETRY_EN
  logic [N-1:0] retry_status;
`endif

  axi_txn_sequencer #(
    .NUM_CH(N), .INIT_PULSE_CYCLES(P), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T), .TMO_W(TW)
  ) dut (
    .ACLK(aclk), .ARESETN(aresetn), .start(start), .chan_mask(chan_mask),
    .init_txn(init_txn), .txn_done(txn_done), .txn_error(txn_error),
    .busy(busy), .seq_done(seq_done), .err_status(err_status),
    .tmo_status(tmo_status), .cur_chan(cur_chan)
`ifdef AXI_TXN_SEQ_RETRY_EN
    , .retry_status(retry_status)
`endif
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  // Slave behaviour per channel, j = cycles since its init rise:
  // mode 0: done rises at j=d1; mode 1: never; mode 2: high, falls at d1, rises at d2.
  int   mode [N];
  int   d1   [N];
  int   d2   [N];
  logic errf [N];
  int   rise_k [N];

  // waveform index: 0 init_txn, 1 busy, 2 seq_done, 3 cur_chan, 4 err_status, 5 tmo_status
  logic [7:0] act_w [6][MAXL];
  logic [7:0] exp_w [6][MAXL];
  string sig_name [6] = '{"init_txn", "busy", "seq_done", "cur_chan", "err_status", "tmo_status"};
  int seq_len, s_fin, t0;

  function automatic logic done_val(int c, int j);
    case (mode[c])
      0: return j >= d1[c];
      2: return (j < d1[c]) || (j >= d2[c]);
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_chan(int c, int m, int a, int b, logic e);
    mode[c] = m; d1[c] = a; d2[c] = b; errf[c] = e;
  endtask

  task automatic rand_chan(int c);
    int r;
    r = $urandom_range(0, 9);
    mode[c] = (r < 7) ? 0 : ((r < 9) ? 1 : 2);
    d1[c] = $urandom_range(0, 110);
    d2[c] = d1[c] + $urandom_range(1, 60);
    errf[c] = 1'($urandom_range(0, 1));
  endtask

  // Called once per negedge: track init rises and drive done/error; other cycles get junk.
  task automatic drive_slaves();
    for (int c = 0; c < N; c++) begin
      logic v;
      if (rise_k[c] < 0 && init_txn[c]) rise_k[c] = cyc;
      if (rise_k[c] < 0) v = (mode[c] == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      else v = done_val(c, cyc - rise_k[c]);
      txn_done[c]  = v;
      txn_error[c] = v ? errf[c] : 1'($urandom_range(0, 1));
    end
  endtask

  // Reference timeline, index 0 = the cycle right after the accepted start edge.
  task automatic build_expected(logic [N-1:0] mask);
    int s, r, pe, we, n;
    int seg [N];
    int stat_t [N];
    logic e_set [N];
    logic t_set [N];
    logic found;
    s = 0;
    for (int i = 0; i < MAXL; i++) exp_w[0][i] = 8'h00;
    for (int c = 0; c < N; c++) begin
      seg[c] = s; e_set[c] = 1'b0; t_set[c] = 1'b0; stat_t[c] = MAXL;
      if (mask[c]) begin
        r = s + 1 + G;
        for (int i = 0; i < P; i++) exp_w[0][r+i] = 8'(1 << c);
        pe = r + P;
        found = 1'b0; n = 0;
        for (int k = 1; k <= T && !found; k++)
          if (done_val(c, P + k - 1) && !done_val(c, P + k - 2)) begin found = 1'b1; n = k; end
        if (found) begin we = pe + n; e_set[c] = errf[c]; end
        else begin we = pe + T; t_set[c] = 1'b1; end
        stat_t[c] = we;
        s = we + 1;
      end else begin
        s = s + 1;
      end
    end
    s_fin = s;
    seq_len = s + 4;
    for (int i = 0; i < seq_len; i++) begin
      logic [7:0] cu, e, t;
      cu = 0; e = 0; t = 0;
      for (int c = 0; c < N; c++) begin
        if (seg[c] <= i) cu = 8'(c);
        if (e_set[c] && i >= stat_t[c]) e[c] = 1'b1;
        if (t_set[c] && i >= stat_t[c]) t[c] = 1'b1;
      end
      exp_w[1][i] = 8'(i <= s_fin);
      exp_w[2][i] = 8'(i == s_fin + 1);
      exp_w[3][i] = cu;
      exp_w[4][i] = e;
      exp_w[5][i] = t;
    end
  endtask

  // Issue one start and capture every output per cycle; optional stray starts while busy.
  task automatic run_seq(logic [N-1:0] mask, logic spurious);
    @(negedge aclk);
    for (int c = 0; c < N; c++) rise_k[c] = -1;
    build_expected(mask);
    drive_slaves();
    chan_mask = mask;
    start = 1'b1;
    t0 = cyc + 1;
    for (int i = 0; i < seq_len; i++) begin
      @(negedge aclk);
      act_w[0][i] = 8'(init_txn);
      act_w[1][i] = 8'(busy);
      act_w[2][i] = 8'(seq_done);
      act_w[3][i] = 8'(cur_chan);
      act_w[4][i] = 8'(err_status);
      act_w[5][i] = 8'(tmo_status);
      drive_slaves();
      chan_mask = N'($urandom);
      start = spurious && (i <= s_fin + 1) && (i == s_fin + 1 || $urandom_range(0, 7) == 0);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1 aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    compared++; if (init_txn !== 3'b000) begin mismatched++; $display("FAIL reset init_txn: got %b expected 000", init_txn); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset busy: got %b expected 0", busy); end
    compared++; if (seq_done !== 1'b0) begin mismatched++; $display("FAIL reset seq_done: got %b expected 0", seq_done); end
    compared++; if (err_status !== 3'b000) begin mismatched++; $display("FAIL reset err_status: got %b expected 000", err_status); end
    compared++; if (tmo_status !== 3'b000) begin mismatched++; $display("FAIL reset tmo_status: got %b expected 000", tmo_status); end
    compared++; if (cur_chan !== 3'd0) begin mismatched++; $display("FAIL reset cur_chan: got %0d expected 0", cur_chan); end
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic test_all_channels();
    int nsd;
    for (int c = 0; c < N; c++) set_chan(c, 0, 50, 0, 1'b0);
    run_seq(3'b111, 1'b0);
    for (int s = 0; s < 6; s++) begin
      compared++;
      for (int i = 0; i < seq_len; i++)
        if (act_w[s][i] !== exp_w[s][i]) begin
          mismatched++;
          $display("FAIL all_ch %s cycle %0d: got %0h expected %0h", sig_name[s], i, act_w[s][i], exp_w[s][i]);
          break;
        end
    end
    nsd = 0;
    for (int i = 0; i < seq_len; i++) if (act_w[2][i] == 8'h01) nsd++;
    compared++; if (nsd !== 1) begin mismatched++; $display("FAIL all_ch seq_done_count: got %0d expected 1", nsd); end
    compared++; if ({err_status, tmo_status} !== 6'b000000) begin mismatched++; $display("FAIL all_ch status: got %b/%b expected 000/000", err_status, tmo_status); end
  endtask

  task automatic test_skip();
    int n1, c1;
    for (int c = 0; c < N; c++) set_chan(c, 0, $urandom_range(10, 60), 0, 1'b0);
    run_seq(3'b101, 1'b0);
    for (int s = 0; s < 6; s++) begin
      compared++;
      for (int i = 0; i < seq_len; i++)
        if (act_w[s][i] !== exp_w[s][i]) begin
          mismatched++;
          $display("FAIL skip %s cycle %0d: got %0h expected %0h", sig_name[s], i, act_w[s][i], exp_w[s][i]);
          break;
        end
    end
    n1 = 0; c1 = 0;
    for (int i = 0; i < seq_len; i++) begin
      if (act_w[0][i][1]) n1++;
      if (act_w[3][i] == 8'd1) c1++;
    end
    compared++; if (n1 !== 0) begin mismatched++; $display("FAIL skip ch1_pulse_cycles: got %0d expected 0", n1); end
    compared++; if (c1 !== 1) begin mismatched++; $display("FAIL skip cur_chan1_cycles: got %0d expected 1", c1); end
  endtask

  task automatic test_error();
    for (int c = 0; c < N; c++) set_chan(c, 0, 50, 0, 1'b0);
    errf[1] = 1'b1;
    run_seq(3'b111, 1'b0);
    for (int s = 0; s < 6; s++) begin
      compared++;
      for (int i = 0; i < seq_len; i++)
        if (act_w[s][i] !== exp_w[s][i]) begin
          mismatched++;
          $display("FAIL error %s cycle %0d: got %0h expected %0h", sig_name[s], i, act_w[s][i], exp_w[s][i]);
          break;
        end
    end
    compared++; if ({err_status, tmo_status} !== 6'b010000) begin mismatched++; $display("FAIL error status: got %b/%b expected 010/000", err_status, tmo_status); end
  endtask

  task automatic test_timeout();
    int last, ft;
    set_chan(0, 0, $urandom_range(2, 60), 0, 1'b0);
    set_chan(1, 0, $urandom_range(2, 60), 0, 1'b0);
    set_chan(2, 1, 0, 0, 1'b0);
    run_seq(3'b111, 1'b0);
    for (int s = 0; s < 6; s++) begin
      compared++;
      for (int i = 0; i < seq_len; i++)
        if (act_w[s][i] !== exp_w[s][i]) begin
          mismatched++;
          $display("FAIL timeout %s cycle %0d: got %0h expected %0h", sig_name[s], i, act_w[s][i], exp_w[s][i]);
          break;
        end
    end
    last = -1; ft = -1;
    for (int i = 0; i < seq_len; i++) begin
      if (act_w[0][i][2]) last = i;
      if (ft < 0 && act_w[5][i][2]) ft = i;
    end
    compared++; if (ft - (last + 1) !== T) begin mismatched++; $display("FAIL timeout delay: got %0d expected %0d", ft - (last + 1), T); end
    compared++; if (tmo_status !== 3'b100) begin mismatched++; $display("FAIL timeout tmo_status: got %b expected 100", tmo_status); end
    // done on the last allowed wait cycle completes; one cycle later times out
    set_chan(0, 0, T + P - 1, 0, 1'b0);
    set_chan(1, 0, T + P, 0, 1'b0);
    set_chan(2, 0, 40, 0, 1'b0);
    run_seq(3'b111, 1'b0);
    for (int s = 0; s < 6; s++) begin
      compared++;
      for (int i = 0; i < seq_len; i++)
        if (act_w[s][i] !== exp_w[s][i]) begin
          mismatched++;
          $display("FAIL tmo_edge %s cycle %0d: got %0h expected %0h", sig_name[s], i, act_w[s][i], exp_w[s][i]);
          break;
        end
    end
    compared++; if (tmo_status !== 3'b010) begin mismatched++; $display("FAIL tmo_edge tmo_status: got %b expected 010", tmo_status); end
  endtask

  task automatic test_held_done();
    for (int k = 0; k < 2; k++) begin
      set_chan(0, 2, (k == 0) ? 30 : 1000, 45, 1'b0);
      set_chan(1, 0, 50, 0, 1'b0);
      set_chan(2, 0, 50, 0, 1'b0);
      run_seq(3'b111, 1'b0);
      for (int s = 0; s < 6; s++) begin
        compared++;
        for (int i = 0; i < seq_len; i++)
          if (act_w[s][i] !== exp_w[s][i]) begin
            mismatched++;
            $display("FAIL held%0d %s cycle %0d: got %0h expected %0h", k, sig_name[s], i, act_w[s][i], exp_w[s][i]);
            break;
          end
      end
      compared++;
      if (tmo_status !== ((k == 0) ? 3'b000 : 3'b001)) begin
        mismatched++;
        $display("FAIL held%0d tmo_status: got %b expected %b", k, tmo_status, (k == 0) ? 3'b000 : 3'b001);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int c = 0; c < N; c++) rand_chan(c);
      run_seq(N'($urandom), 1'b0);
      for (int s = 0; s < 6; s++) begin
        compared++;
        for (int i = 0; i < seq_len; i++)
          if (act_w[s][i] !== exp_w[s][i]) begin
            mismatched++;
            $display("FAIL rand%0d %s cycle %0d: got %0h expected %0h", it, sig_name[s], i, act_w[s][i], exp_w[s][i]);
            break;
          end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 3; it++) begin
      for (int c = 0; c < N; c++) rand_chan(c);
      run_seq(N'($urandom), 1'b1);
      for (int s = 0; s < 6; s++) begin
        compared++;
        for (int i = 0; i < seq_len; i++)
          if (act_w[s][i] !== exp_w[s][i]) begin
            mismatched++;
            $display("FAIL b2b%0d %s cycle %0d: got %0h expected %0h", it, sig_name[s], i, act_w[s][i], exp_w[s][i]);
            break;
          end
      end
    end
  endtask

  task automatic test_async_reset();
    logic hit;
    for (int c = 0; c < N; c++) begin set_chan(c, 0, 50, 0, 1'b0); rise_k[c] = -1; end
    @(negedge aclk);
    drive_slaves();
    chan_mask = 3'b111;
    start = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      @(negedge aclk);
      start = 1'b0;
      drive_slaves();
      if (init_txn[1]) hit = 1'b1;
    end
    compared++;
    if (!hit) begin
      mismatched++;
      $display("FAIL arst wait_ch1_pulse: got no pulse expected init_txn[1] within 1000 cycles");
    end
    #2 aresetn = 1'b0;
    #1;
    compared++; if (init_txn !== 3'b000) begin mismatched++; $display("FAIL arst init_txn: got %b expected 000", init_txn); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL arst busy: got %b expected 0", busy); end
    compared++; if (cur_chan !== 3'd0) begin mismatched++; $display("FAIL arst cur_chan: got %0d expected 0", cur_chan); end
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    for (int c = 0; c < N; c++) set_chan(c, 0, 50, 0, 1'b0);
    run_seq(3'b111, 1'b0);
    for (int s = 0; s < 6; s++) begin
      compared++;
      for (int i = 0; i < seq_len; i++)
        if (act_w[s][i] !== exp_w[s][i]) begin
          mismatched++;
          $display("FAIL arst_rerun %s cycle %0d: got %0h expected %0h", sig_name[s], i, act_w[s][i], exp_w[s][i]);
          break;
        end
    end
  endtask

  initial begin
    for (int c = 0; c < N; c++) begin set_chan(c, 1, 0, 0, 1'b0); rise_k[c] = -1; end
    test_reset();
    test_all_channels();
    test_skip();
    test_error();
    test_timeout();
    test_held_done();
    test_random();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/axi_txn_sequencer.md
Name: axi_txn_sequencer

Overview:
- Controller that sequences the per-port transaction-initiate handshakes of the multi-master AXI splitter (M00..M0N-1 INIT_AXI_TXN / TXN_DONE / ERROR).
- On one start pulse it launches each enabled master port in ascending order. It waits for completion or timeout on each port, records per-port error and timeout status, then reports overall done.
- Replaces the hand-timed init sequencing in benches and lets software run the splitter self-tests in hardware.

Parameters:
- NUM_CH, 3, number of master ports sequenced (1..8).
- INIT_PULSE_CYCLES, 2, width of each init_txn pulse in ACLK cycles (>=1).
- GAP_CYCLES, 20, idle ACLK cycles before each channel's init pulse (>=0).
- TIMEOUT_CYCLES, 4096, maximum cycles waited for txn_done after the pulse ends (>=1).
- TMO_W, 16, width of the timeout/gap/pulse counter; must hold max(INIT_PULSE_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES).

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to run a sequence; ignored while busy.
- chan_mask  in  NUM_CH  enabled channels; sampled on the accepted start.
- init_txn  out  NUM_CH  one-hot init pulse to the master port's INIT_AXI_TXN.
- txn_done  in  NUM_CH  master port TXN_DONE (level).
- txn_error  in  NUM_CH  master port ERROR (level).
- busy  out  1  sequence in progress.
- seq_done  out  1  one-cycle pulse when a sequence completes.
- err_status  out  NUM_CH  per-channel error flag, sticky until next start.
- tmo_status  out  NUM_CH  per-channel timeout flag, sticky until next start.
- cur_chan  out  3  index of the channel currently being serviced.

Behaviour:
- Reset (async assert, sync release): state IDLE; init_txn=0, busy=0, seq_done=0, err_status=0, tmo_status=0, cur_chan=0, counters=0.
- IDLE: start=1 -> latch chan_mask to mask_q, clear err_status/tmo_status, busy=1 next cycle, cur_chan=0 -> SELECT.
- SELECT: if mask_q[cur_chan]=1 -> GAP with counter=0. Else, if cur_chan==NUM_CH-1 -> FINISH, otherwise cur_chan+1 and stay in SELECT.
  - A channel skip costs one cycle.
  - mask_q=0 -> FINISH after NUM_CH SELECT cycles.
- GAP: count GAP_CYCLES cycles (0 -> leave immediately) -> PULSE.
- PULSE: init_txn[cur_chan]=1 for exactly INIT_PULSE_CYCLES cycles, all other bits 0. Then capture done_prev=txn_done[cur_chan] -> WAIT.
- WAIT: completion is a rising edge of txn_done[cur_chan] relative to the registered previous value. A done already high at entry does not count.
  - On completion: err_status[cur_chan] <= txn_error[cur_chan] sampled that cycle -> NEXT.
  - Timeout: counter reaches TIMEOUT_CYCLES with no edge -> tmo_status[cur_chan]=1 -> NEXT.
  - If the edge and the timeout occur in the same cycle, completion wins and tmo is not set.
- NEXT: cur_chan==NUM_CH-1 -> FINISH, else cur_chan+1 -> SELECT.
- FINISH: seq_done=1 for one cycle, busy=0 -> IDLE. cur_chan holds its last value.
- start while busy is ignored, including during FINISH. start in the same cycle seq_done is high is ignored.
- txn_done/txn_error of non-current channels are ignored.
- ARESETN low mid-sequence: init_txn drops to 0 immediately (asynchronously) and all state returns to reset values.
- init_txn is registered, so there is no combinational path from inputs to init_txn.

Optional Feature:
- Macro AXI_TXN_SEQ_RETRY_EN.
- Defined: on error or timeout, a channel is retried once (GAP -> PULSE -> WAIT again) before NEXT.
  - Status reflects only the retry's outcome.
  - Adds output retry_status [NUM_CH], set when a retry occurred on that channel and cleared on start.
- Undefined: no retry, no retry_status port; failure goes directly to NEXT.

Test Plan:
- Reset, then start with chan_mask=3'b111, each model raising done 50 cycles after init with error=0:
  - init_txn pulses 001, 010, 100, each 2 cycles wide, preceded by 20-cycle gaps.
  - seq_done pulses once; err_status=0, tmo_status=0.
- chan_mask=3'b101: channel 1 is never pulsed; cur_chan passes through 1 for one cycle; seq_done is asserted.
- Channel 1 model asserts error=1 with done: err_status=3'b010, tmo_status=0, channels 0 and 2 complete normally.
- Channel 2 never raises done, TIMEOUT_CYCLES=100: tmo_status=3'b100 exactly 100 cycles after the pulse ends, then seq_done.
- Channel 0 done held high from before start: no completion until done falls and rises again; otherwise timeout is flagged.
- ARESETN dropped during channel 1's PULSE: init_txn=0 within the same cycle, busy=0; a new start after release runs cleanly from channel 0.
